// File: rtl/controle_medida.sv
// rtl/controle_medida.sv - measurement-sequence controller (limp/hab/arm strobes)
// Optional completed-measurement counter n_medidas enabled by CONTROLE_MEDIDAS_EN.
module controle_medida #(
  parameter int GATE_W      = 16,
  parameter int LIMP_CYC    = 1,
  parameter int LIMPA_CICLO = 1
`ifdef CONTROLE_MEDIDAS_EN
  , parameter int CNT_W     = 16
`endif
) (
  input  logic              clk_controle,
  input  logic              reset,
  input  logic              start,
  input  logic              continuo,
  input  logic              parar,
  input  logic [GATE_W-1:0] tempo_hab,
  output logic              limp,
  output logic              hab,
  output logic              arm,
  output logic              ocupado
`ifdef CONTROLE_MEDIDAS_EN
  , output logic [CNT_W-1:0] n_medidas
`endif
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LIMPA    = 3'd1;
  localparam logic [2:0] ESPERA1  = 3'd2;
  localparam logic [2:0] HABILITA = 3'd3;
  localparam logic [2:0] ESPERA2  = 3'd4;
  localparam logic [2:0] ARMAZENA = 3'd5;

  localparam logic [GATE_W-1:0] ONE       = GATE_W'(1);
  localparam logic [GATE_W-1:0] LIMP_INIT = GATE_W'(LIMP_CYC - 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [GATE_W-1:0] timer;
  logic [GATE_W-1:0] tempo_reg;
  logic [GATE_W-1:0] tempo_load;
  logic              parar_pend;
  logic              repete;

  // A zero gate length would never reach timer==0 cleanly, so it is promoted to one cycle.
  assign tempo_load = (tempo_hab == '0) ? ONE : tempo_hab;
  assign repete     = continuo && !parar_pend && !parar;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start && !parar) state_nxt = LIMPA;
      LIMPA:    if (timer == '0) state_nxt = ESPERA1;
      ESPERA1:  state_nxt = HABILITA;
      HABILITA: if (timer == '0) state_nxt = ESPERA2;
      ESPERA2:  state_nxt = ARMAZENA;
      ARMAZENA: begin
        if (repete) state_nxt = (LIMPA_CICLO != 0) ? LIMPA : ESPERA1;
        else        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so each is high exactly while in its state.
  always_ff @(posedge clk_controle or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      limp    <= 1'b0;
      hab     <= 1'b0;
      arm     <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      state   <= state_nxt;
      limp    <= (state_nxt == LIMPA);
      hab     <= (state_nxt == HABILITA);
      arm     <= (state_nxt == ARMAZENA);
      ocupado <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk_controle or posedge reset) begin
    if (reset) begin
      timer     <= '0;
      tempo_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (state_nxt == LIMPA) begin
            timer     <= LIMP_INIT;
            tempo_reg <= tempo_load;
          end
        end
        LIMPA:    if (timer != '0) timer <= timer - ONE;
        ESPERA1:  timer <= tempo_reg - ONE;
        HABILITA: if (timer != '0) timer <= timer - ONE;
        ARMAZENA: begin
          if (state_nxt == LIMPA) begin
            timer     <= LIMP_INIT;
            tempo_reg <= tempo_load;
          end else if (state_nxt == ESPERA1) begin
            tempo_reg <= tempo_load;
          end
        end
        default: ;
      endcase
    end
  end

  // A stop request is remembered until the running measurement has been stored.
  always_ff @(posedge clk_controle or posedge reset) begin
    if (reset)                   parar_pend <= 1'b0;
    else if (state_nxt == IDLE)  parar_pend <= 1'b0;
    else if (parar && ocupado)   parar_pend <= 1'b1;
  end

`ifdef CONTROLE_MEDIDAS_EN
  always_ff @(posedge clk_controle or posedge reset) begin
    if (reset)                  n_medidas <= '0;
    else if (state == ARMAZENA) n_medidas <= n_medidas + CNT_W'(1);
  end
`endif

endmodule
